pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (D->E, E->M, M->W) for the MIPS core.
//  Carries instruction, PC, operands, register indices, write address A3 and the
//  T_new countdown. It adds three things to the fixed D->E register:
//   - separate hold (freeze) and bubble (insert NOP) controls;
//   - a forward-ready flag for the hazard unit;
//   - saturating bubble and hold performance counters.
// PARAMETERS
//  DATA_W  32  width of instr/pc/v1/v2/imm/wd fields
//  REG_W   5   register index width (rs/rt/rd/a3)
//  TNEW_W  2   T_new countdown width
//  CNT_W   16  width of each performance counter
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       asynchronous, active-high
//  hold          in   1       freeze stage: all fields keep their value
//  bubble        in   1       load a NOP (all-zero fields, valid=0)
//  in_valid      in   1       upstream slot holds a real instruction
//  in_instr      in   DATA_W  instruction word
//  in_pc         in   DATA_W  instruction PC
//  in_v1, in_v2  in   DATA_W  operand values
//  in_imm        in   DATA_W  extended immediate
//  in_rs/rt/rd   in   REG_W   source/destination indices
//  in_a3         in   REG_W   GPR write address (0 = no write)
//  in_tnew       in   TNEW_W  cycles until result ready, at upstream stage
//  in_wd         in   DATA_W  result value if already produced upstream
//  out_*         out  as in   registered copies of every in_* field (incl. out_valid)
//  fwd_ready     out  1       out_valid && out_a3!=0 && out_tnew==0
//  bubble_cnt    out  CNT_W   number of bubble loads
//  hold_cnt      out  CNT_W   number of hold cycles
// BEHAVIOUR
//  - Asynchronous reset drives every output to 0: all fields, out_valid,
//    fwd_ready and both counters.
//  - Each rising edge applies the first matching case, in priority order:
//     1. bubble: every field <- 0, out_valid <- 0, bubble_cnt++.
//     2. hold: all fields unchanged, out_tnew NOT decremented, hold_cnt++.
//     3. otherwise load: every out_* <- in_*;
//        out_tnew <- (in_tnew==0) ? 0 : in_tnew-1 (saturating at 0).
//  - bubble and hold together: bubble wins. Only bubble_cnt increments.
//  - A load with in_valid=0 forces out_a3 to 0, so an invalid slot never forwards.
//  - Both counters saturate at 2^CNT_W-1. They do not wrap.
//  - Latency: one cycle from in_* to out_*. fwd_ready is derived combinationally
//    from registered state, so it has no extra delay.
//  - Reset asserted mid-operation clears immediately. The first edge after reset
//    releases behaves as a normal load.
//  - No X propagation: every register is covered by reset.
// STRUCTURE
//  - pipe_pkg holds TNEW_W and REG_W defaults, NOP_INSTR=32'h0 and ZERO_REG=0.
//  - Sub-module pipe_field_reg #(W):
//     - async reset;
//     - inputs clr (bubble) and en (!hold);
//     - one instance per field.
//  - The T_new decrement logic, the counters and fwd_ready live in the top module.
// TESTING
//  1. reset=1 mid-run with out_pc=0x3004 -> all outputs 0 immediately, before
//     any clock edge; bubble_cnt=0.
//  2. Load in_tnew=2, in_a3=5, in_valid=1 -> next edge out_tnew=1, fwd_ready=0.
//     Then load in_tnew=0 -> out_tnew=0, fwd_ready=1.
//  3. hold=1 for 3 edges with out_pc=0x3008, out_tnew=1 -> outputs stay
//     unchanged; hold_cnt=3.
//  4. hold=1 and bubble=1 on the same edge -> out_instr=0, out_valid=0,
//     bubble_cnt+1, hold_cnt unchanged.
//  5. in_valid=0, in_a3=7, in_tnew=0 -> out_a3=0, fwd_ready=0.
//  6. CNT_W=2 with 5 consecutive bubbles -> bubble_cnt=3 and stays at 3.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared defaults and constants for the inter-stage pipeline registers.
package pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int TNEW_W_DEF = 2;
    localparam int CNT_W_DEF  = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int unsigned ZERO_REG  = 0;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream bundle of one pipeline stage register, with stage controls and counters.
interface pipe_stage_reg_if #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int REG_W  = pipe_pkg::REG_W_DEF,
    parameter int TNEW_W = pipe_pkg::TNEW_W_DEF,
    parameter int CNT_W  = pipe_pkg::CNT_W_DEF
);
    logic              hold;
    logic              bubble;
    logic              in_valid;
    logic [DATA_W-1:0] in_instr, in_pc, in_v1, in_v2, in_imm, in_wd;
    logic [REG_W-1:0]  in_rs, in_rt, in_rd, in_a3;
    logic [TNEW_W-1:0] in_tnew;

    logic              out_valid;
    logic [DATA_W-1:0] out_instr, out_pc, out_v1, out_v2, out_imm, out_wd;
    logic [REG_W-1:0]  out_rs, out_rt, out_rd, out_a3;
    logic [TNEW_W-1:0] out_tnew;
    logic              fwd_ready;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  hold_cnt;

    modport master (
        output hold, bubble, in_valid, in_instr, in_pc, in_v1, in_v2, in_imm, in_wd,
               in_rs, in_rt, in_rd, in_a3, in_tnew,
        input  out_valid, out_instr, out_pc, out_v1, out_v2, out_imm, out_wd,
               out_rs, out_rt, out_rd, out_a3, out_tnew, fwd_ready, bubble_cnt, hold_cnt
    );

    modport slave (
        input  hold, bubble, in_valid, in_instr, in_pc, in_v1, in_v2, in_imm, in_wd,
               in_rs, in_rt, in_rd, in_a3, in_tnew,
        output out_valid, out_instr, out_pc, out_v1, out_v2, out_imm, out_wd,
               out_rs, out_rt, out_rd, out_a3, out_tnew, fwd_ready, bubble_cnt, hold_cnt
    );
endinterface

// File: rtl/pipe_stage_reg_field.sv
// One field of a stage register: clear (bubble) beats enable (not hold).
module pipe_field_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold/bubble controls, T_new countdown,
// forward-ready flag and saturating bubble/hold counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int TNEW_W = TNEW_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset,
    pipe_stage_reg_if.slave  bus
);
    logic              en;
    logic [REG_W-1:0]  a3_d;
    logic [TNEW_W-1:0] tnew_d;
    logic [CNT_W-1:0]  bubble_q, hold_q;

    assign en = !bus.hold;

    // An invalid slot must never advertise a write target to the hazard unit.
    assign a3_d   = bus.in_valid ? bus.in_a3 : REG_W'(ZERO_REG);
    assign tnew_d = (bus.in_tnew == '0) ? '0 : bus.in_tnew - TNEW_W'(1);

    pipe_field_reg #(.W(1))      u_valid (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_valid), .q(bus.out_valid));
    pipe_field_reg #(.W(DATA_W)) u_instr (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_instr), .q(bus.out_instr));
    pipe_field_reg #(.W(DATA_W)) u_pc    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_pc),    .q(bus.out_pc));
    pipe_field_reg #(.W(DATA_W)) u_v1    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_v1),    .q(bus.out_v1));
    pipe_field_reg #(.W(DATA_W)) u_v2    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_v2),    .q(bus.out_v2));
    pipe_field_reg #(.W(DATA_W)) u_imm   (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_imm),   .q(bus.out_imm));
    pipe_field_reg #(.W(DATA_W)) u_wd    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_wd),    .q(bus.out_wd));
    pipe_field_reg #(.W(REG_W))  u_rs    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_rs),    .q(bus.out_rs));
    pipe_field_reg #(.W(REG_W))  u_rt    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_rt),    .q(bus.out_rt));
    pipe_field_reg #(.W(REG_W))  u_rd    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(bus.in_rd),    .q(bus.out_rd));
    pipe_field_reg #(.W(REG_W))  u_a3    (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(a3_d),         .q(bus.out_a3));
    pipe_field_reg #(.W(TNEW_W)) u_tnew  (.clk(clk), .reset(reset), .clr(bus.bubble), .en(en), .d(tnew_d),       .q(bus.out_tnew));

    // Bubble outranks hold, so a combined request counts only as a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_q <= '0;
            hold_q   <= '0;
        end else if (bus.bubble) begin
            if (bubble_q != '1)
                bubble_q <= bubble_q + CNT_W'(1);
        end else if (bus.hold) begin
            if (hold_q != '1)
                hold_q <= hold_q + CNT_W'(1);
        end
    end

    assign bus.bubble_cnt = bubble_q;
    assign bus.hold_cnt   = hold_q;
    assign bus.fwd_ready  = bus.out_valid && (bus.out_a3 != REG_W'(ZERO_REG)) && (bus.out_tnew == '0);
endmodule
